starsoc_vga_timing: RTL

Parametrised video timing generator for the starsoc display path. It divides the system clock into a pixel tick and runs horizontal and vertical counters over the full visible, front porch, sync and back porch intervals. It produces hsync, vsync, video_on, line/frame strobes and a frame counter. Geometry, sync polarity and clock divide are generics, so the same block serves 640x480@60 and other modes. It feeds the pixel/colour generator and the game-logic frame tick.

---
 rtl/starsoc_vga_timing.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/starsoc_vga_timing.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters, sync/blank decode, strobes.
// Optional macro STARSOC_VGA_PIPE_EN registers hsync/vsync/video_on one pixel slot behind the counters.
module starsoc_vga_timing #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 4,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int FRAME_CNT_W = 16,
    localparam int H_MAX = H_VISIBLE + H_FP + H_SYNC + H_BP - 1,
    localparam int V_MAX = V_VISIBLE + V_FP + V_SYNC + V_BP - 1,
    localparam int H_W   = $clog2(H_MAX + 1),
    localparam int V_W   = $clog2(V_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   pix_tick,
    output logic [H_W-1:0]         hcount,
    output logic [V_W-1:0]         vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   video_on,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST    = H_W'(H_MAX);
    localparam logic [H_W-1:0]   H_VIS_END = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0]   HS_FIRST  = H_W'(H_VISIBLE + H_FP);
    localparam logic [H_W-1:0]   HS_LAST   = H_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]   V_LAST    = V_W'(V_MAX);
    localparam logic [V_W-1:0]   V_VIS_END = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0]   VS_FIRST  = V_W'(V_VISIBLE + V_FP);
    localparam logic [V_W-1:0]   VS_LAST   = V_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic             HS_ACT    = 1'(HSYNC_POL);
    localparam logic             VS_ACT    = 1'(VSYNC_POL);

    logic [DIV_W-1:0]       div_r;
    logic [H_W-1:0]         hcount_r;
    logic [V_W-1:0]         vcount_r;
    logic                   line_start_r;
    logic                   frame_start_r;
    logic [FRAME_CNT_W-1:0] frame_count_r;
    logic                   tick_s;
    logic                   h_last_s;
    logic                   v_last_s;
    logic                   hsync_dec_s;
    logic                   vsync_dec_s;
    logic                   video_on_dec_s;

    // Pixel tick and end-of-line / end-of-frame conditions
    always_comb begin
        tick_s   = en && (div_r == DIV_LAST);
        h_last_s = (hcount_r == H_LAST);
        v_last_s = (vcount_r == V_LAST);
    end

    // Clock divider: advances only while enabled, so a pause resumes at the same phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
        end else if (en) begin
            div_r <= (div_r == DIV_LAST) ? '0 : div_r + DIV_W'(1);
        end else begin
            div_r <= div_r;
        end
    end

    // Horizontal and vertical position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_r <= '0;
            vcount_r <= '0;
        end else if (tick_s) begin
            if (h_last_s) begin
                hcount_r <= '0;
                vcount_r <= v_last_s ? '0 : vcount_r + V_W'(1);
            end else begin
                hcount_r <= hcount_r + H_W'(1);
                vcount_r <= vcount_r;
            end
        end else begin
            hcount_r <= hcount_r;
            vcount_r <= vcount_r;
        end
    end

    // Wrap strobes and completed-frame count; the post-reset origin produces no strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= '0;
        end else begin
            line_start_r  <= tick_s && h_last_s;
            frame_start_r <= tick_s && h_last_s && v_last_s;
            if (tick_s && h_last_s && v_last_s) begin
                frame_count_r <= frame_count_r + FRAME_CNT_W'(1);
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    // Sync and blanking decode from the current position
    always_comb begin
        hsync_dec_s    = ((hcount_r >= HS_FIRST) && (hcount_r <= HS_LAST)) ? HS_ACT : ~HS_ACT;
        vsync_dec_s    = ((vcount_r >= VS_FIRST) && (vcount_r <= VS_LAST)) ? VS_ACT : ~VS_ACT;
        video_on_dec_s = (hcount_r < H_VIS_END) && (vcount_r < V_VIS_END);
    end

`ifdef STARSOC_VGA_PIPE_EN
    logic hsync_r;
    logic vsync_r;
    logic video_on_r;

    // One-slot delayed decode to line up with a single-stage pixel/ROM pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r    <= ~HS_ACT;
            vsync_r    <= ~VS_ACT;
            video_on_r <= 1'b1;
        end else if (tick_s) begin
            hsync_r    <= hsync_dec_s;
            vsync_r    <= vsync_dec_s;
            video_on_r <= video_on_dec_s;
        end else begin
            hsync_r    <= hsync_r;
            vsync_r    <= vsync_r;
            video_on_r <= video_on_r;
        end
    end

    assign hsync    = hsync_r;
    assign vsync    = vsync_r;
    assign video_on = video_on_r;
`else
    assign hsync    = hsync_dec_s;
    assign vsync    = vsync_dec_s;
    assign video_on = video_on_dec_s;
`endif

    assign pix_tick    = tick_s;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_count = frame_count_r;

endmodule
